// File: rtl/rf_wb_arbiter_if.sv
// Request channels (ALU write-back, LSU load-return) and the shared RF write port.
// The arbiter uses the slave modport; requesters and the RF see the master side.
interface rf_wb_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              alu_hl;

    logic              lsu_valid;
    logic              lsu_ready;
    logic [ADDR_W-1:0] lsu_reg;
    logic [DATA_W-1:0] lsu_data;
    logic              lsu_hl;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_write_reg;
    logic [DATA_W-1:0] rf_data_in;
    logic              rf_hl;

    modport master (
        output alu_valid, alu_reg, alu_data, alu_hl,
        output lsu_valid, lsu_reg, lsu_data, lsu_hl,
        input  alu_ready, lsu_ready,
        input  rf_we, rf_write_reg, rf_data_in, rf_hl
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data, alu_hl,
        input  lsu_valid, lsu_reg, lsu_data, lsu_hl,
        output alu_ready, lsu_ready,
        output rf_we, rf_write_reg, rf_data_in, rf_hl
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// RF write-port arbiter between ALU write-back and LSU load-return, with a
// per-register busy scoreboard for outstanding loads and RAW hazard detection.
module rf_wb_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned NREGS      = 16,
    parameter int unsigned STARVE_MAX = 2
) (
    input  logic              clk,
    input  logic              reset,
    rf_wb_arbiter_if.slave    bus,
    input  logic              ld_issue,
    input  logic [ADDR_W-1:0] ld_reg,
    input  logic [ADDR_W-1:0] rd_port1,
    input  logic [ADDR_W-1:0] rd_port2,
    output logic              hazard,
    output logic [NREGS-1:0]  busy_vec
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [NREGS-1:0]  busy_q, busy_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_write_reg_q;
    logic [DATA_W-1:0] rf_data_in_q;
    logic              rf_hl_q;

    logic alu_elig_c;
    logic alu_gnt_c;
    logic lsu_gnt_c;

    // Grant selection: LSU by default, ALU when idle LSU or starvation limit reached.
    // ALU writes to a register with a load in flight are held off (WAW).
    always_comb begin
        alu_elig_c = 1'b0;
        alu_gnt_c  = 1'b0;
        lsu_gnt_c  = 1'b0;
        busy_d     = busy_q;
        starve_d   = starve_q;

        alu_elig_c = bus.alu_valid & ~busy_q[bus.alu_reg];
        if (!reset) begin
            if (alu_elig_c && (!bus.lsu_valid || starve_q == CNT_W'(STARVE_MAX))) begin
                alu_gnt_c = 1'b1;
            end else if (bus.lsu_valid) begin
                lsu_gnt_c = 1'b1;
            end
        end

        if (alu_gnt_c || !alu_elig_c) begin
            starve_d = '0;
        end else if (lsu_gnt_c && starve_q != CNT_W'(STARVE_MAX)) begin
            starve_d = starve_q + CNT_W'(1);
        end

        // Clear before set so a re-issued load to the same register stays busy.
        if (lsu_gnt_c) begin
            busy_d[bus.lsu_reg] = 1'b0;
        end
        if (ld_issue) begin
            busy_d[ld_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q         <= '0;
            starve_q       <= '0;
            rf_we_q        <= 1'b0;
            rf_write_reg_q <= '0;
            rf_data_in_q   <= '0;
            rf_hl_q        <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            starve_q <= starve_d;
            rf_we_q  <= alu_gnt_c | lsu_gnt_c;
            if (alu_gnt_c) begin
                rf_write_reg_q <= bus.alu_reg;
                rf_data_in_q   <= bus.alu_data;
                rf_hl_q        <= bus.alu_hl;
            end else if (lsu_gnt_c) begin
                rf_write_reg_q <= bus.lsu_reg;
                rf_data_in_q   <= bus.lsu_data;
                rf_hl_q        <= bus.lsu_hl;
            end
        end
    end

    assign bus.alu_ready    = alu_gnt_c;
    assign bus.lsu_ready    = lsu_gnt_c;
    assign bus.rf_we        = rf_we_q;
    assign bus.rf_write_reg = rf_write_reg_q;
    assign bus.rf_data_in   = rf_data_in_q;
    assign bus.rf_hl        = rf_hl_q;

    assign hazard   = busy_q[rd_port1] | busy_q[rd_port2] | (ld_issue & busy_q[ld_reg]);
    assign busy_vec = busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios followed by randomized traffic,
// all checked against a behavioural model of the arbitration and scoreboard rules.
module tb_rf_wb_arbiter;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned NREGS      = 16;
    localparam int unsigned STARVE_MAX = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              ld_issue;
    logic [ADDR_W-1:0] ld_reg;
    logic [ADDR_W-1:0] rd_port1;
    logic [ADDR_W-1:0] rd_port2;
    logic              hazard;
    logic [NREGS-1:0]  busy_vec;

    rf_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rf_wb_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .ld_issue (ld_issue),
        .ld_reg   (ld_reg),
        .rd_port1 (rd_port1),
        .rd_port2 (rd_port2),
        .hazard   (hazard),
        .busy_vec (busy_vec)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [NREGS-1:0]  m_busy   = '0;
    int                m_starve = 0;
    logic              exp_we   = 1'b0;
    logic [ADDR_W-1:0] exp_reg  = '0;
    logic [DATA_W-1:0] exp_data = '0;
    logic              exp_hl   = 1'b0;
    logic              exp_ar, exp_lr, exp_hz;
    logic              alu_acc  = 1'b0;
    logic              lsu_acc  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_comb();
        bit alu_ok;
        alu_ok = bus.alu_valid && !m_busy[bus.alu_reg];
        exp_ar = 1'b0;
        exp_lr = 1'b0;
        if (!reset) begin
            if (alu_ok && (!bus.lsu_valid || m_starve == STARVE_MAX)) exp_ar = 1'b1;
            else if (bus.lsu_valid) exp_lr = 1'b1;
        end
        exp_hz = m_busy[rd_port1] || m_busy[rd_port2] || (ld_issue && m_busy[ld_reg]);
    endtask

    task automatic model_seq();
        bit alu_ok;
        alu_ok  = bus.alu_valid && !m_busy[bus.alu_reg];
        alu_acc = exp_ar;
        lsu_acc = exp_lr;
        if (reset) begin
            m_busy   = '0;
            m_starve = 0;
            exp_we   = 1'b0;
            exp_reg  = '0;
            exp_data = '0;
            exp_hl   = 1'b0;
        end else begin
            exp_we = exp_ar || exp_lr;
            if (exp_ar) begin
                exp_reg = bus.alu_reg; exp_data = bus.alu_data; exp_hl = bus.alu_hl;
            end else if (exp_lr) begin
                exp_reg = bus.lsu_reg; exp_data = bus.lsu_data; exp_hl = bus.lsu_hl;
            end
            if (exp_ar || !alu_ok) m_starve = 0;
            else if (exp_lr && m_starve < STARVE_MAX) m_starve = m_starve + 1;
            if (exp_lr) m_busy[bus.lsu_reg] = 1'b0;
            if (ld_issue) m_busy[ld_reg] = 1'b1;
        end
    endtask

    // One clock: inputs are set at the falling edge before the call.
    task automatic cycle();
        #1;
        model_comb();
        check("alu_ready", 64'(bus.alu_ready), 64'(exp_ar));
        check("lsu_ready", 64'(bus.lsu_ready), 64'(exp_lr));
        check("hazard",    64'(hazard),        64'(exp_hz));
        @(posedge clk);
        model_seq();
        #1;
        check("rf_we",        64'(bus.rf_we),        64'(exp_we));
        check("rf_write_reg", 64'(bus.rf_write_reg), 64'(exp_reg));
        check("rf_data_in",   64'(bus.rf_data_in),   64'(exp_data));
        check("rf_hl",        64'(bus.rf_hl),        64'(exp_hl));
        check("busy_vec",     64'(busy_vec),         64'(m_busy));
        @(negedge clk);
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0; bus.alu_hl = 1'b0;
        bus.lsu_valid = 1'b0; bus.lsu_reg = '0; bus.lsu_data = '0; bus.lsu_hl = 1'b0;
        ld_issue = 1'b0; ld_reg = '0; rd_port1 = '0; rd_port2 = '0;
    endtask

    initial begin
        logic g;
        logic [3:0] pat;

        // Power-on reset with both requesters asserting
        idle();
        reset = 1'b1;
        bus.alu_valid = 1'b1;
        bus.lsu_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
        check("rst_lsu_ready", 64'(bus.lsu_ready), 64'd0);
        check("rst_rf_we",     64'(bus.rf_we),     64'd0);
        check("rst_rf_reg",    64'(bus.rf_write_reg), 64'd0);
        check("rst_rf_data",   64'(bus.rf_data_in), 64'd0);
        check("rst_rf_hl",     64'(bus.rf_hl),     64'd0);
        check("rst_busy",      64'(busy_vec),      64'd0);
        idle();
        reset = 1'b0;

        // Single ALU write
        bus.alu_valid = 1'b1; bus.alu_reg = 4'd5; bus.alu_data = 32'hDEADBEEF; bus.alu_hl = 1'b1;
        #1 check("single_ready", 64'(bus.alu_ready), 64'd1);
        cycle();
        check("single_we",   64'(bus.rf_we),        64'd1);
        check("single_reg",  64'(bus.rf_write_reg), 64'd5);
        check("single_data", 64'(bus.rf_data_in),   64'hDEADBEEF);
        check("single_hl",   64'(bus.rf_hl),        64'd1);
        idle();
        cycle();
        check("single_we_off", 64'(bus.rf_we), 64'd0);

        // Contention: expected grant pattern LSU, LSU, ALU, LSU
        pat = 4'b0100;
        bus.alu_valid = 1'b1; bus.alu_reg = 4'd3; bus.alu_data = 32'hA1A1A1A1;
        bus.lsu_valid = 1'b1; bus.lsu_reg = 4'd7; bus.lsu_data = 32'hB2B2B2B2;
        for (int i = 0; i < 4; i++) begin
            #1 g = bus.alu_ready;
            check("cont_alu_gnt", 64'(g), 64'(pat[i]));
            cycle();
        end
        idle();
        cycle();

        // Scoreboard and WAW hold-off
        ld_issue = 1'b1; ld_reg = 4'd9;
        cycle();
        check("sb_busy9", 64'(busy_vec[9]), 64'd1);
        idle();
        bus.alu_valid = 1'b1; bus.alu_reg = 4'd9; bus.alu_data = 32'hCAFE0009;
        rd_port1 = 4'd9;
        #1;
        check("waw_alu_ready", 64'(bus.alu_ready), 64'd0);
        check("waw_hazard",    64'(hazard),        64'd1);
        cycle();
        bus.lsu_valid = 1'b1; bus.lsu_reg = 4'd9; bus.lsu_data = 32'h12345678;
        cycle();
        check("ld9_data", 64'(bus.rf_data_in), 64'h12345678);
        check("ld9_busy", 64'(busy_vec[9]),    64'd0);
        bus.lsu_valid = 1'b0;
        cycle();
        check("waw_alu_reg",  64'(bus.rf_write_reg), 64'd9);
        check("waw_alu_data", 64'(bus.rf_data_in),   64'hCAFE0009);
        idle();

        // Same-cycle set and clear of register 4
        ld_issue = 1'b1; ld_reg = 4'd4;
        cycle();
        bus.lsu_valid = 1'b1; bus.lsu_reg = 4'd4; bus.lsu_data = 32'h44440004;
        cycle();
        check("setclr_busy4", 64'(busy_vec[4]),    64'd1);
        check("setclr_data",  64'(bus.rf_data_in), 64'h44440004);
        check("setclr_we",    64'(bus.rf_we),      64'd1);
        idle();

        // Reset mid-write
        bus.alu_valid = 1'b1; bus.alu_reg = 4'd2; bus.alu_data = 32'h22222222;
        cycle();
        bus.lsu_valid = 1'b1; bus.lsu_reg = 4'd6;
        reset = 1'b1;
        #1;
        check("midrst_alu_ready", 64'(bus.alu_ready), 64'd0);
        check("midrst_lsu_ready", 64'(bus.lsu_ready), 64'd0);
        cycle();
        check("midrst_we",   64'(bus.rf_we), 64'd0);
        check("midrst_busy", 64'(busy_vec),  64'd0);
        reset = 1'b0;
        idle();
        cycle();

        // Randomized traffic; requesters hold until accepted
        alu_acc = 1'b0;
        lsu_acc = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!bus.alu_valid || alu_acc) begin
                bus.alu_valid = ($urandom_range(0, 99) < 60);
                bus.alu_reg   = ADDR_W'($urandom);
                bus.alu_data  = DATA_W'($urandom);
                bus.alu_hl    = 1'($urandom);
            end
            if (!bus.lsu_valid || lsu_acc) begin
                bus.lsu_valid = ($urandom_range(0, 99) < 50);
                bus.lsu_reg   = ADDR_W'($urandom);
                bus.lsu_data  = DATA_W'($urandom);
                bus.lsu_hl    = 1'($urandom);
            end
            ld_issue = ($urandom_range(0, 99) < 30);
            ld_reg   = ADDR_W'($urandom);
            rd_port1 = ADDR_W'($urandom);
            rd_port2 = ADDR_W'($urandom);
            reset    = ($urandom_range(0, 99) < 2);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
